// File: rtl/i2s_slave.sv
// I2S slave receiver/transmitter running entirely in the mclk domain.
// lrck, sclk and sdin are resynchronized, and the block acts on each sclk
// rising edge seen in the mclk domain. A left+right pair is published
// together with a one-cycle pvalid. Transmit words are loaded at each
// channel change and shifted out MSB first.
module i2s_slave #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             mclk,
   input  logic             srst,
   input  logic             lrck,
   input  logic             sclk,
   input  logic             sdin,
   output logic [WIDTH-1:0] pldout,
   output logic [WIDTH-1:0] prdout,
   output logic             pvalid,
   output logic             ferr,
   output logic             sdout,
   input  logic [WIDTH-1:0] pldin,
   input  logic [WIDTH-1:0] prdin,
   output logic             ptake
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   lr_q, lr_d;
   logic                   armed_q, armed_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-2:0]       rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0]       stage_q, stage_d;
   logic                   stage_vld_q, stage_vld_d;
   logic [WIDTH-1:0]       pldout_q, pldout_d;
   logic [WIDTH-1:0]       prdout_q, prdout_d;
   logic                   pvalid_q, pvalid_d;
   logic                   ferr_q, ferr_d;
   logic                   ptake_q, ptake_d;
   logic [WIDTH-1:0]       tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0]       hold_q, hold_d;

   logic             lrck_s, sclk_s, sdin_s;
   logic             rise, chg, complete;
   logic [WIDTH-1:0] rx_word;

   assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign sdin_s  = sdin_sync_q[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_dly_q;
   assign chg     = rise & (lrck_s != lr_q);
   assign rx_word = {rx_sr_q, sdin_s};

   // Synchronizer chains: new sample enters at bit 0.
   always_comb begin
      lrck_sync_d = (lrck_sync_q << 1) | SYNC_STAGES'(lrck);
      sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(sclk);
      sdin_sync_d = (sdin_sync_q << 1) | SYNC_STAGES'(sdin);
      sclk_dly_d  = sclk_s;
   end

   // Per-rise receive/transmit handling and pair publication.
   always_comb begin
      lr_d        = lr_q;
      armed_d     = armed_q;
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      stage_d     = stage_q;
      stage_vld_d = stage_vld_q;
      pldout_d    = pldout_q;
      prdout_d    = prdout_q;
      pvalid_d    = 1'b0;
      ferr_d      = 1'b0;
      ptake_d     = 1'b0;
      tx_sr_d     = tx_sr_q;
      hold_d      = hold_q;
      complete    = 1'b0;
      if (rise) begin
         lr_d = lrck_s;
         if (chg) begin
            // The delay slot after a channel change carries the outgoing LSB.
            armed_d = 1'b1;
            cnt_d   = '0;
            if (armed_q) begin
               if (cnt_q == CNT_LAST) begin
                  complete = 1'b1;
               end else if (cnt_q != CNT_FULL) begin
                  ferr_d = 1'b1;
               end
            end
            if (!lrck_s) begin
               tx_sr_d = pldin;
               hold_d  = prdin;
               ptake_d = 1'b1;
            end else begin
               tx_sr_d = hold_q;
            end
         end else begin
            if (armed_q && (cnt_q != CNT_FULL)) begin
               rx_sr_d = rx_word[WIDTH-2:0];
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  complete = 1'b1;
               end
            end
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
         end
      end
      // lr_q still holds the channel the completed word belongs to.
      if (complete) begin
         if (!lr_q) begin
            stage_d     = rx_word;
            stage_vld_d = 1'b1;
         end else if (stage_vld_q) begin
            pldout_d    = stage_q;
            prdout_d    = rx_word;
            pvalid_d    = 1'b1;
            stage_vld_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge mclk) begin
      if (srst) begin
         lrck_sync_q <= '0;
         sclk_sync_q <= '0;
         sdin_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         lr_q        <= 1'b0;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         rx_sr_q     <= '0;
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
         pldout_q    <= '0;
         prdout_q    <= '0;
         pvalid_q    <= 1'b0;
         ferr_q      <= 1'b0;
         ptake_q     <= 1'b0;
         tx_sr_q     <= '0;
         hold_q      <= '0;
      end else begin
         lrck_sync_q <= lrck_sync_d;
         sclk_sync_q <= sclk_sync_d;
         sdin_sync_q <= sdin_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         lr_q        <= lr_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         pldout_q    <= pldout_d;
         prdout_q    <= prdout_d;
         pvalid_q    <= pvalid_d;
         ferr_q      <= ferr_d;
         ptake_q     <= ptake_d;
         tx_sr_q     <= tx_sr_d;
         hold_q      <= hold_d;
      end
   end

   assign pldout = pldout_q;
   assign prdout = prdout_q;
   assign pvalid = pvalid_q;
   assign ferr   = ferr_q;
   assign ptake  = ptake_q;
   assign sdout  = tx_sr_q[WIDTH-1];

endmodule

// File: tb/tb_i2s_slave.sv
// Bench for i2s_slave: an I2S master drives frames described as a list of
// half-frames (channel, sclk count, word); a word-level model predicts the
// published pairs, ferr/ptake counts and the sdout bit seen at every sclk rise.
module tb_i2s_slave;
   localparam int W    = 32;
   localparam int MAXH = 16;
   localparam int MAXS = 512;

   logic         mclk = 1'b0, srst = 1'b1, lrck = 1'b0, sclk = 1'b0;
   logic         sdin_m = 1'b0, loop = 1'b0;
   logic         sdin_w;
   logic [W-1:0] pldout, prdout;
   logic [W-1:0] pldin = '0, prdin = '0;
   logic         pvalid, ferr, sdout, ptake;

   assign sdin_w = loop ? sdout : sdin_m;

   i2s_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .mclk(mclk), .srst(srst), .lrck(lrck), .sclk(sclk), .sdin(sdin_w),
      .pldout(pldout), .prdout(prdout), .pvalid(pvalid), .ferr(ferr),
      .sdout(sdout), .pldin(pldin), .prdin(prdin), .ptake(ptake));

   always #10 mclk = ~mclk;

   int vec = 0, miss = 0;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {logic [W-1:0] l; logic [W-1:0] r;} pair_t;
   pair_t        exp_q[$];
   pair_t        cmp_p;
   logic         m_lr, m_armed, m_stage_vld;
   logic [W-1:0] m_stage, m_hold;
   int           exp_ferr, exp_ptake, seen_ferr, seen_ptake, seen_pvalid;
   logic [W-1:0] cur_l = '0, cur_r = '0;
   bit           chk_en = 1'b0;

   int           h_n;
   logic         h_chan[MAXH];
   int           h_len[MAXH];
   logic [W-1:0] h_word[MAXH];

   // Continuous output check against the model's last published pair.
   always @(negedge mclk) begin
      if (chk_en) begin
         if (pvalid) begin
            seen_pvalid++;
            if (exp_q.size() == 0) check("pvalid_unexpected", W'(pvalid), '0);
            else begin
               cmp_p = exp_q.pop_front();
               cur_l = cmp_p.l;
               cur_r = cmp_p.r;
            end
         end
         check("pldout", pldout, cur_l);
         check("prdout", prdout, cur_r);
         if (ferr)  seen_ferr++;
         if (ptake) seen_ptake++;
      end
   end

   task automatic do_reset();
      chk_en = 1'b0;
      @(posedge mclk); #2 srst = 1'b1;
      sclk = 1'b0;
      @(posedge mclk); @(negedge mclk);
      check("rst_pldout", pldout, '0);
      check("rst_prdout", prdout, '0);
      check("rst_pvalid", W'(pvalid), '0);
      check("rst_ferr", W'(ferr), '0);
      check("rst_sdout", W'(sdout), '0);
      check("rst_ptake", W'(ptake), '0);
      m_lr = 1'b0; m_armed = 1'b0; m_stage_vld = 1'b0; m_stage = '0; m_hold = '0;
      exp_q.delete();
      exp_ferr = 0; exp_ptake = 0; seen_ferr = 0; seen_ptake = 0; seen_pvalid = 0;
      cur_l = '0; cur_r = '0;
      @(posedge mclk); #2 srst = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic set_half(input int i, input logic c, input int n, input logic [W-1:0] w);
      h_chan[i] = c; h_len[i] = n; h_word[i] = w;
   endtask

   task automatic slot(input logic lr, input logic d, input logic exp_sd);
      lrck = lr; sdin_m = d;
      #80 sclk = 1'b1;
      check("sdout", W'(sdout), W'(exp_sd));
      #80 sclk = 1'b0;
   endtask

   task automatic run_halves();
      int           s_start[MAXH];
      int           nslots;
      logic         sl_lr[MAXS];
      logic         sl_d[MAXS];
      logic         sl_sd[MAXS];
      logic [W-1:0] tx_w, rw;
      bit           chg;
      pair_t        pp;
      nslots = 0;
      for (int h = 0; h < h_n; h++) begin
         s_start[h] = nslots;
         nslots += h_len[h];
      end
      for (int t = 0; t <= nslots; t++) begin
         sl_lr[t] = 1'b0; sl_d[t] = 1'b0; sl_sd[t] = 1'b0;
      end
      for (int h = 0; h < h_n; h++) begin
         chg  = (h_chan[h] != m_lr);
         m_lr = h_chan[h];
         tx_w = '0;
         if (chg) begin
            m_armed = 1'b1;
            if (!h_chan[h]) begin
               tx_w = pldin; m_hold = prdin; exp_ptake++;
            end else tx_w = m_hold;
         end
         rw = loop ? tx_w : h_word[h];
         for (int k = 0; k < h_len[h]; k++) sl_lr[s_start[h] + k] = h_chan[h];
         for (int k = 1; k <= h_len[h]; k++)
            sl_sd[s_start[h] + k] = (k - 1 < W) ? tx_w[W - k] : 1'b0;
         for (int j = 0; j < W; j++)
            if (j + 1 <= h_len[h]) sl_d[s_start[h] + 1 + j] = rw[W - 1 - j];
         if (m_armed && (h_len[h] > W || (h + 1 < h_n && h_len[h] == W))) begin
            if (!h_chan[h]) begin
               m_stage = rw; m_stage_vld = 1'b1;
            end else if (m_stage_vld) begin
               pp.l = m_stage; pp.r = rw;
               exp_q.push_back(pp);
               m_stage_vld = 1'b0;
            end
         end else if (m_armed && h + 1 < h_n && h_len[h] < W) begin
            exp_ferr++;
         end
      end
      for (int t = 0; t < nslots; t++) slot(sl_lr[t], sl_d[t], sl_sd[t]);
      repeat (12) @(posedge mclk);
      #2;
      check("pvalid_missing", W'(exp_q.size()), '0);
      check("ferr_count", W'(seen_ferr), W'(exp_ferr));
      check("ptake_count", W'(seen_ptake), W'(exp_ptake));
   endtask

   initial begin
      pldin = 32'h3C3C0FF0; prdin = 32'h96969696;

      // Basic pair, preceded by an unpaired right word that must stay hidden.
      do_reset();
      h_n = 5;
      set_half(0, 1'b0, 4, '0);
      set_half(1, 1'b1, 32, 32'hCAFEF00D);
      set_half(2, 1'b0, 32, 32'h80000001);
      set_half(3, 1'b1, 32, 32'h12345678);
      set_half(4, 1'b0, 2, '0);
      run_halves();
      check("basic_pldout_lit", pldout, 32'h80000001);
      check("basic_prdout_lit", prdout, 32'h12345678);
      check("basic_pvalid_cnt_lit", W'(seen_pvalid), 32'd1);

      // Loopback of sdout into sdin.
      pldin = 32'hA5A5A5A5; prdin = 32'h0000FFFF; loop = 1'b1;
      do_reset();
      h_n = 7;
      set_half(0, 1'b0, 4, '0);
      set_half(1, 1'b1, 32, '0);
      set_half(2, 1'b0, 32, '0);
      set_half(3, 1'b1, 32, '0);
      set_half(4, 1'b0, 32, '0);
      set_half(5, 1'b1, 32, '0);
      set_half(6, 1'b0, 2, '0);
      run_halves();
      loop = 1'b0;
      check("loop_pldout_lit", pldout, 32'hA5A5A5A5);
      check("loop_prdout_lit", prdout, 32'h0000FFFF);
      check("loop_ptake_cnt_lit", W'(seen_ptake), 32'd3);
      check("loop_pvalid_cnt_lit", W'(seen_pvalid), 32'd2);

      // 48 sclk per half: padding on both directions.
      pldin = 32'hDEADBEEF; prdin = 32'hDEADBEEF;
      do_reset();
      h_n = 5;
      set_half(0, 1'b0, 4, '0);
      set_half(1, 1'b1, 48, 32'hDEADBEEF);
      set_half(2, 1'b0, 48, 32'hDEADBEEF);
      set_half(3, 1'b1, 48, 32'hDEADBEEF);
      set_half(4, 1'b0, 2, '0);
      run_halves();
      check("long_pldout_lit", pldout, 32'hDEADBEEF);
      check("long_prdout_lit", prdout, 32'hDEADBEEF);
      check("long_ferr_cnt_lit", W'(seen_ferr), 32'd0);

      // 16 sclk per half: every armed channel change is a short word.
      pldin = 32'h3C3C0FF0; prdin = 32'h96969696;
      do_reset();
      h_n = 6;
      set_half(0, 1'b0, 4, '0);
      set_half(1, 1'b1, 16, 32'h11111111);
      set_half(2, 1'b0, 16, 32'h22222222);
      set_half(3, 1'b1, 16, 32'h33333333);
      set_half(4, 1'b0, 16, 32'h44444444);
      set_half(5, 1'b1, 2, '0);
      run_halves();
      check("short_ferr_cnt_lit", W'(seen_ferr), 32'd4);
      check("short_pvalid_cnt_lit", W'(seen_pvalid), 32'd0);
      check("short_pldout_lit", pldout, 32'h0);

      // Stream that starts directly in a right phase.
      do_reset();
      h_n = 6;
      set_half(0, 1'b1, 32, 32'h0BADF00D);
      set_half(1, 1'b0, 32, 32'h01234567);
      set_half(2, 1'b1, 32, 32'h89ABCDEF);
      set_half(3, 1'b0, 32, 32'h55AA55AA);
      set_half(4, 1'b1, 32, 32'hAA55AA55);
      set_half(5, 1'b0, 2, '0);
      run_halves();
      check("rstart_pvalid_cnt_lit", W'(seen_pvalid), 32'd2);
      check("rstart_pldout_lit", pldout, 32'h55AA55AA);
      check("rstart_prdout_lit", prdout, 32'hAA55AA55);

      // Reset in the middle of a left word.
      do_reset();
      h_n = 4;
      set_half(0, 1'b1, 4, '0);
      set_half(1, 1'b0, 32, 32'h11112222);
      set_half(2, 1'b1, 32, 32'h33334444);
      set_half(3, 1'b0, 10, 32'h55556666);
      run_halves();
      check("prerst_pldout_lit", pldout, 32'h11112222);
      do_reset();
      h_n = 5;
      set_half(0, 1'b0, 22, '0);
      set_half(1, 1'b1, 32, 32'h77778888);
      set_half(2, 1'b0, 32, 32'h9999AAAA);
      set_half(3, 1'b1, 32, 32'hBBBBCCCC);
      set_half(4, 1'b0, 2, '0);
      run_halves();
      check("postrst_pvalid_cnt_lit", W'(seen_pvalid), 32'd1);
      check("postrst_pldout_lit", pldout, 32'h9999AAAA);
      check("postrst_prdout_lit", prdout, 32'hBBBBCCCC);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
